// File: rtl/axi_ram_pkg.sv
// Shared constants for the AXI4 RAM slave.
// FSM encoding, response codes and burst-length width.
package axi_ram_pkg;

  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_WR    = 2'd2;
  localparam logic [1:0] ST_WRESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_ram_bram.sv
// Single-port synchronous RAM, per-byte write enable, registered read.
// Ports: clk, reset, re, we[NB], addr, wdata -> rdata (1-cycle latency).
module axi_ram_bram #(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    re,
  input  logic [DATA_W/8-1:0]     we,
  input  logic [MEM_ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Output holds whenever re is low (R-channel stall).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave RAM: single-beat writes and INCR bursts, one txn at a time.
// Ports: clk, reset (async, active-low), AXI AR/R/AW/W/B channels.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int AXI_ID_W   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_W-1:0]     axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [AXI_ID_W-1:0]   axi_arid,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_W-1:0]     axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic [AXI_ID_W-1:0]   axi_rid,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_W-1:0]     axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [AXI_ID_W-1:0]   axi_awid,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_W-1:0]     axi_wdata,
  input  logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  output logic [AXI_ID_W-1:0]   axi_bid
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = $clog2(NBYTES);

  logic [1:0]            state;
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_ADDR_W-1:0] addr_nxt;
  logic [AXI_LEN_W-1:0]  len;
  logic [AXI_LEN_W-1:0]  cnt;
  logic [AXI_ID_W-1:0]   id;
  logic                  err;

  logic aw_hs, ar_hs, r_hs, w_hs, last;

  logic                  ram_re;
  logic [NBYTES-1:0]     ram_we;
  logic [MEM_ADDR_W-1:0] ram_addr;

  // Address bits outside the word index are ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{axi_araddr, axi_awaddr};

  assign addr_nxt = addr + 1'b1;
  assign last     = (cnt == len);

  assign aw_hs = (state == ST_IDLE) && axi_awvalid;
  assign ar_hs = (state == ST_IDLE) && axi_arvalid && !axi_awvalid;
  assign r_hs  = (state == ST_RD) && axi_rready;
  assign w_hs  = (state == ST_WR) && axi_wvalid;

  assign axi_awready = (state == ST_IDLE);
  assign axi_arready = (state == ST_IDLE) && !axi_awvalid;
  assign axi_wready  = (state == ST_WR);
  assign axi_rvalid  = (state == ST_RD);
  assign axi_rlast   = (state == ST_RD) && last;
  assign axi_rresp   = RESP_OKAY;
  assign axi_rid     = id;
  assign axi_bvalid  = (state == ST_WRESP);
  assign axi_bresp   = (axi_bvalid && err) ? RESP_SLVERR : RESP_OKAY;
  assign axi_bid     = id;

  // Next read is issued on the same edge as the accepting handshake,
  // so back-to-back beats stream at one per cycle.
  always_comb begin
    ram_addr = addr;
    ram_re   = 1'b0;
    ram_we   = '0;
    if (ar_hs) begin
      ram_addr = axi_araddr[BYTE_W +: MEM_ADDR_W];
      ram_re   = 1'b1;
    end else if (r_hs && !last) begin
      ram_addr = addr_nxt;
      ram_re   = 1'b1;
    end
    if (w_hs) ram_we = axi_wstrb;
  end

  axi_ram_bram #(
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_bram (
    .clk   (clk),
    .reset (reset),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (axi_wdata),
    .rdata (axi_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      id    <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            state <= ST_WR;
            addr  <= axi_awaddr[BYTE_W +: MEM_ADDR_W];
            len   <= axi_awlen;
            cnt   <= '0;
            id    <= axi_awid;
          end else if (ar_hs) begin
            state <= ST_RD;
            addr  <= axi_araddr[BYTE_W +: MEM_ADDR_W];
            len   <= axi_arlen;
            cnt   <= '0;
            id    <= axi_arid;
          end
        end
        ST_RD: begin
          if (r_hs) begin
            if (last) begin
              state <= ST_IDLE;
            end else begin
              addr <= addr_nxt;
              cnt  <= cnt + 1'b1;
            end
          end
        end
        ST_WR: begin
          if (w_hs) begin
            // Beat counter decides the end; wlast only flags errors.
            if (axi_wlast != last) err <= 1'b1;
            addr <= addr_nxt;
            cnt  <= cnt + 1'b1;
            if (last) state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (axi_bready) begin
            err   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave.
// Drives/samples on the falling edge; handshakes complete on rising edge.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arid;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rid;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awid;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        bid;

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .clk         (clk),
    .reset       (reset),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_araddr  (araddr),
    .axi_arlen   (arlen),
    .axi_arid    (arid),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .axi_rlast   (rlast),
    .axi_rid     (rid),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_awaddr  (awaddr),
    .axi_awlen   (awlen),
    .axi_awid    (awid),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wlast   (wlast),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_bresp   (bresp),
    .axi_bid     (bid)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wq [$];
  logic [31:0] rd_q [$];
  logic        rl_q [$];
  logic        rid_seen;
  int          r_cycles;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len,
                           input logic id, input logic [3:0] strb,
                           input bit bad_last, input bit with_ar,
                           output logic [1:0] resp, output logic bidv,
                           output int bwait, output logic ar_rdy);
    int t;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; awlen = len; awid = id;
    if (with_ar) begin
      arvalid = 1'b1; araddr = a; arlen = 8'd0; arid = 1'b0;
    end
    #1;
    ar_rdy = arready;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); #1; t++; end
    if (t >= 50) check("aw_timeout", 1, 0);
    @(negedge clk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wvalid = 1'b1;
      wdata  = wq[k];
      wstrb  = strb;
      wlast  = bad_last ? 1'b1 : (k == int'(len));
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("w_timeout", 1, 0);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    bwait  = 0;
    while (!bvalid && bwait < 50) begin @(negedge clk); bwait++; end
    resp = bresp;
    bidv = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                         input logic id);
    int t;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arlen = len; arid = id;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ar_timeout", 1, 0);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic r_collect(input logic [3:0] pat, input int nbeats);
    int t;
    bit stalled;
    logic [31:0] held;
    rd_q.delete();
    rl_q.delete();
    t = 0;
    stalled = 1'b0;
    held = '0;
    while (rd_q.size() < nbeats && t < 2000) begin
      rready = pat[t % 4];
      if (stalled && rvalid) check("r_hold", rdata, held);
      if (rvalid && rready) begin
        rd_q.push_back(rdata);
        rl_q.push_back(rlast);
        rid_seen = rid;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1;
        held = rdata;
      end
      t++;
      @(negedge clk);
    end
    rready = 1'b0;
    r_cycles = t;
    if (t >= 2000) check("r_timeout", 1, 0);
    check("r_done_rvalid", rvalid, 0);
  endtask

  task automatic check_burst(input string tag, input int n,
                             input logic [31:0] base);
    logic [7:0] lv;
    lv = '0;
    check({tag, "_beats"}, rd_q.size(), n);
    for (int k = 0; k < n && k < rd_q.size(); k++) begin
      check({tag, "_data"}, rd_q[k], base + k);
      lv[k] = rl_q[k];
    end
    check({tag, "_rlast"}, lv, 8'h1 << (n - 1));
  endtask

  logic [1:0] resp;
  logic       bidv, ar_rdy;
  int         bw;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    arvalid = 0; araddr = 0; arlen = 0; arid = 0; rready = 0;
    awvalid = 0; awaddr = 0; awlen = 0; awid = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 1);
    reset = 1'b1;

    // single-beat write then read back
    wq = '{32'hDEADBEEF};
    axi_write(32'h10, 8'd0, 1'b0, 4'hF, 1'b0, 1'b0, resp, bidv, bw, ar_rdy);
    check("wr1_bresp", resp, 2'b00);
    check("wr1_bwait", bw, 0);
    ar_send(32'h10, 8'd0, 1'b0);
    check("rd1_lat", rvalid, 1);
    r_collect(4'hF, 1);
    check("rd1_data", rd_q[0], 32'hDEADBEEF);
    check("rd1_rlast", rl_q[0], 1);

    // preload 1..8 and full-speed refill
    wq.delete();
    for (int k = 0; k < 8; k++) wq.push_back(32'(k + 1));
    axi_write(32'h100, 8'd7, 1'b1, 4'hF, 1'b0, 1'b0, resp, bidv, bw, ar_rdy);
    check("wr8_bresp", resp, 2'b00);
    check("wr8_bid", bidv, 1);
    ar_send(32'h100, 8'd7, 1'b1);
    check("rd8_lat", rvalid, 1);
    r_collect(4'hF, 8);
    check_burst("rd8", 8, 32'd1);
    check("rd8_rid", rid_seen, 1);
    check("rd8_cycles", r_cycles, 8);

    // same refill under rready 1,0,0,1
    ar_send(32'h100, 8'd7, 1'b0);
    r_collect(4'b1001, 8);
    check_burst("bp", 8, 32'd1);
    check("bp_rid", rid_seen, 0);
    check("bp_cycles", r_cycles, 16);

    // byte strobes; AW wins over simultaneous AR
    wq = '{32'h11223344};
    axi_write(32'h200, 8'd0, 1'b0, 4'hF, 1'b0, 1'b0, resp, bidv, bw, ar_rdy);
    wq = '{32'hAABBCCDD};
    axi_write(32'h200, 8'd0, 1'b1, 4'h5, 1'b0, 1'b1, resp, bidv, bw, ar_rdy);
    check("arb_arready", ar_rdy, 0);
    check("arb_bid", bidv, 1);
    ar_send(32'h200, 8'd0, 1'b0);
    r_collect(4'hF, 1);
    check("strb_data", rd_q[0], 32'h11BB33DD);

    // wlast on the wrong beat -> SLVERR, data still written
    wq = '{32'h55, 32'h66};
    axi_write(32'h300, 8'd1, 1'b0, 4'hF, 1'b1, 1'b0, resp, bidv, bw, ar_rdy);
    check("err_bresp", resp, 2'b10);
    ar_send(32'h300, 8'd1, 1'b0);
    r_collect(4'hF, 2);
    check("err_d0", rd_q[0], 32'h55);
    check("err_d1", rd_q[1], 32'h66);

    // wrap from top word to word 0; error flag cleared
    wq = '{32'hA1, 32'hA2};
    axi_write(32'h3FFFC, 8'd1, 1'b0, 4'hF, 1'b0, 1'b0, resp, bidv, bw, ar_rdy);
    check("wrap_bresp", resp, 2'b00);
    ar_send(32'h0, 8'd0, 1'b0);
    r_collect(4'hF, 1);
    check("wrap_w0", rd_q[0], 32'hA2);
    ar_send(32'h3FFFC, 8'd1, 1'b0);
    r_collect(4'hF, 2);
    check("wrap_r0", rd_q[0], 32'hA1);
    check("wrap_r1", rd_q[1], 32'hA2);

    // reset during beat 3 of 8
    ar_send(32'h100, 8'd7, 1'b1);
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_beat3", rdata, 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rvalid", rvalid, 0);
    check("mid_rlast", rlast, 0);
    rready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_arready", arready, 1);
    check("post_rvalid", rvalid, 0);
    ar_send(32'h100, 8'd7, 1'b0);
    r_collect(4'hF, 8);
    check_burst("post", 8, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
